// File: rtl/vacc_pp.sv
// vacc_pp: ping-pong vector accumulator; integrates into one bank while the other drains.
// Optional VACC_SATURATE_EN: adds clamp at full scale and ovf reports a clamp in the drained integration.
module vacc_pp #(
  parameter int VECTOR_WIDTH = 11,
  parameter int INPUT_WIDTH  = 36,
  parameter int OUTPUT_WIDTH = 64,
  parameter int NACC_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [INPUT_WIDTH-1:0]  data_in,
  input  logic                    sync,
  input  logic                    trig,
  input  logic                    free_run,
  input  logic [NACC_WIDTH-1:0]   n_acc,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic                    we,
  output logic [VECTOR_WIDTH-1:0] addr,
  output logic                    last,
  output logic                    ovf
);
  localparam int NCH = 1 << VECTOR_WIDTH;
  localparam logic [NACC_WIDTH-1:0] NACC_ONE = NACC_WIDTH'(1);

  typedef enum logic [1:0] {WAIT_SYNC, WAIT_TRIG, ARMED, RUN} state_t;

  state_t                  state, state_nxt;
  logic                    synced;
  logic [VECTOR_WIDTH-1:0] chan;
  logic                    chan_last;
  logic                    pending;
  logic [NACC_WIDTH-1:0]   nacc_lat, spec_cnt;
  logic                    acc_bank;
  logic                    start_int, end_int, accum;

  logic                    s1_vld, s1_bank, s1_first;
  logic [VECTOR_WIDTH-1:0] s1_addr;
  logic [INPUT_WIDTH-1:0]  s1_dat;
  logic [OUTPUT_WIDTH-1:0] s1_base, s1_sum;
  logic                    s2_vld, s2_bank;
  logic [VECTOR_WIDTH-1:0] s2_addr;
  logic [OUTPUT_WIDTH-1:0] s2_sum;

  logic                    drain_act, drain_bank;
  logic [VECTOR_WIDTH-1:0] drain_cnt;
  logic                    p1_vld, p1_bank;
  logic [VECTOR_WIDTH-1:0] p1_addr;
  logic [OUTPUT_WIDTH-1:0] p1_rd;

  assign chan_last = (chan == '1);

  always_comb begin
    state_nxt = state;
    start_int = 1'b0;
    end_int   = 1'b0;
    accum     = 1'b0;
    case (state)
      WAIT_SYNC: if (sync) state_nxt = WAIT_TRIG;
      WAIT_TRIG: if (trig || free_run) state_nxt = ARMED;
      ARMED: begin
        if (chan_last) begin
          state_nxt = RUN;
          start_int = 1'b1;
        end
      end
      RUN: begin
        accum = 1'b1;
        if (chan_last && spec_cnt == nacc_lat - NACC_ONE) begin
          end_int = 1'b1;
          // A queued request restarts on the very next spectrum, keeping integrations gapless
          if (free_run || pending || trig) start_int = 1'b1;
          else state_nxt = WAIT_TRIG;
        end
      end
      default: state_nxt = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WAIT_SYNC;
      synced   <= 1'b0;
      chan     <= '0;
      pending  <= 1'b0;
      nacc_lat <= NACC_ONE;
      spec_cnt <= '0;
      acc_bank <= 1'b0;
    end else if (ce) begin
      state <= state_nxt;
      if (!synced) begin
        chan <= '0;
        if (sync) synced <= 1'b1;
      end else begin
        chan <= chan + 1'b1;
      end
      if (end_int) begin
        acc_bank <= ~acc_bank;
        pending  <= 1'b0;
      end else if ((state == ARMED || state == RUN) && trig) begin
        pending <= 1'b1;
      end
      if (start_int) begin
        nacc_lat <= (n_acc == '0) ? NACC_ONE : n_acc;
        spec_cnt <= '0;
      end else if (state == RUN && chan_last) begin
        spec_cnt <= spec_cnt + 1'b1;
      end
    end
  end

  // Each bank's read port serves accumulation when it is the active bank, otherwise the drain
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [OUTPUT_WIDTH-1:0] mem [NCH];
    logic [OUTPUT_WIDTH-1:0] rq;
    logic [VECTOR_WIDTH-1:0] ra;
    assign ra = (accum && acc_bank == 1'(b)) ? chan : drain_cnt;
    always_ff @(posedge clk) begin
      if (ce) begin
        rq <= mem[ra];
        if (s2_vld && s2_bank == 1'(b)) mem[s2_addr] <= s2_sum;
      end
    end
  end

  assign s1_base = s1_first ? '0 : (s1_bank ? g_bank[1].rq : g_bank[0].rq);
  assign p1_rd   = p1_bank ? g_bank[1].rq : g_bank[0].rq;

`ifdef VACC_SATURATE_EN
  logic [OUTPUT_WIDTH:0] s1_wide;
  logic                  s1_clamp;
  logic [1:0]            bank_ovf;
  assign s1_wide  = {1'b0, s1_base} + (OUTPUT_WIDTH+1)'(s1_dat);
  assign s1_clamp = s1_wide[OUTPUT_WIDTH];
  assign s1_sum   = s1_clamp ? '1 : s1_wide[OUTPUT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_ovf <= '0;
      ovf      <= 1'b0;
    end else if (ce) begin
      if (start_int) bank_ovf[end_int ? ~acc_bank : acc_bank] <= 1'b0;
      if (s1_vld && s1_clamp) bank_ovf[s1_bank] <= 1'b1;
      // Flag lands together with the first drained word and holds for the whole drain
      if (p1_vld && p1_addr == '0) ovf <= bank_ovf[p1_bank];
    end
  end
`else
  assign s1_sum = s1_base + OUTPUT_WIDTH'(s1_dat);
  assign ovf    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld     <= 1'b0;
      s1_bank    <= 1'b0;
      s1_first   <= 1'b0;
      s1_addr    <= '0;
      s1_dat     <= '0;
      s2_vld     <= 1'b0;
      s2_bank    <= 1'b0;
      s2_addr    <= '0;
      s2_sum     <= '0;
      drain_act  <= 1'b0;
      drain_bank <= 1'b0;
      drain_cnt  <= '0;
      p1_vld     <= 1'b0;
      p1_bank    <= 1'b0;
      p1_addr    <= '0;
      we         <= 1'b0;
      addr       <= '0;
      last       <= 1'b0;
      data_out   <= '0;
    end else if (ce) begin
      s1_vld   <= accum;
      s1_bank  <= acc_bank;
      s1_first <= (spec_cnt == '0);
      s1_addr  <= chan;
      s1_dat   <= data_in;
      s2_vld   <= s1_vld;
      s2_bank  <= s1_bank;
      s2_addr  <= s1_addr;
      s2_sum   <= s1_sum;

      if (end_int) begin
        drain_act  <= 1'b1;
        drain_bank <= acc_bank;
        drain_cnt  <= '0;
      end else if (drain_act) begin
        drain_cnt <= drain_cnt + 1'b1;
        if (drain_cnt == '1) drain_act <= 1'b0;
      end
      p1_vld  <= drain_act;
      p1_bank <= drain_bank;
      p1_addr <= drain_cnt;

      we       <= p1_vld;
      addr     <= p1_vld ? p1_addr : '0;
      last     <= p1_vld && (p1_addr == '1);
      data_out <= p1_vld ? p1_rd : '0;
    end
  end
endmodule

// File: tb/tb_vacc_pp.sv
// tb_vacc_pp: randomized scenarios for vacc_pp compared against an integration-level sum model.
module tb_vacc_pp;
  localparam int VW = 3;
  localparam int IW = 8;
  localparam int OW = 9;
  localparam int NW = 4;
  localparam int NCH = 1 << VW;
  localparam int unsigned MAXV = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst, ce, sync, trig, free_run;
  logic [IW-1:0] data_in;
  logic [NW-1:0] n_acc;
  logic [OW-1:0] data_out;
  logic          we, last, ovf;
  logic [VW-1:0] addr;

  vacc_pp #(.VECTOR_WIDTH(VW), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .NACC_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .data_in(data_in), .sync(sync), .trig(trig),
    .free_run(free_run), .n_acc(n_acc), .data_out(data_out), .we(we), .addr(addr),
    .last(last), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ccyc = 0;
  int end_cyc;
  int q_dat[$], q_addr[$], q_last[$], q_ovf[$], q_cyc[$];
  int exp_q[$];
  logic [IW-1:0] sp [NCH];
  int unsigned m_acc [NCH];
  bit m_ovf;

  // Every enabled cycle with we high delivers one word
  always @(negedge clk) begin
    if (ce === 1'b1) begin
      if (we === 1'b1 && rst !== 1'b1) begin
        q_dat.push_back(int'(data_out));
        q_addr.push_back(int'(addr));
        q_last.push_back(int'(last));
        q_ovf.push_back(int'(ovf));
        q_cyc.push_back(ccyc);
      end
      ccyc++;
    end
  end

  task automatic clk_cycle(input bit rnd);
    if (rnd) begin
      while ($urandom_range(1, 0) == 1) begin
        ce = 1'b0;
        @(posedge clk); #1;
      end
    end
    ce = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic spectrum(input bit trg, input bit rnd);
    for (int c = 0; c < NCH; c++) begin
      data_in = sp[c];
      trig = trg && (c == 0);
      if (c == NCH - 1) end_cyc = ccyc;
      clk_cycle(rnd);
    end
    trig = 1'b0;
  endtask

  task automatic idle(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      data_in = IW'($urandom);
      clk_cycle(rnd);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; ce = 1'b1; sync = 1'b0; trig = 1'b0; free_run = 1'b0;
    data_in = '0; n_acc = NW'(1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_sync;
    sync = 1'b1;
    clk_cycle(1'b0);
    sync = 1'b0;
  endtask

  task automatic clear_q;
    q_dat.delete(); q_addr.delete(); q_last.delete(); q_ovf.delete(); q_cyc.delete();
    exp_q.delete();
  endtask

  task automatic fill_rand(input int maxv);
    for (int c = 0; c < NCH; c++) sp[c] = IW'($urandom_range(maxv, 0));
  endtask

  task automatic model_add(input bit first);
    if (first) m_ovf = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      int unsigned s;
      s = (first ? 0 : m_acc[c]) + int'(sp[c]);
`ifdef VACC_SATURATE_EN
      if (s > MAXV) begin
        s = MAXV;
        m_ovf = 1'b1;
      end
`else
      s = s % (MAXV + 1);
`endif
      m_acc[c] = s;
    end
  endtask

  task automatic model_push;
    for (int c = 0; c < NCH; c++) exp_q.push_back(int'(m_acc[c]));
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", we); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data got %0d exp 0", data_out); end
    checks++; if (addr !== '0) begin errors++; $display("FAIL reset_addr got %0d exp 0", addr); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", last); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    clear_q();
    do_sync();
    idle(24, 1'b0);
    checks++;
    if (q_dat.size() != 0) begin errors++; $display("FAIL no_trig_drain got %0d words exp 0", q_dat.size()); end
  endtask

  task automatic test_basic;
    int e;
    do_reset(); do_sync(); clear_q();
    n_acc = NW'(4);
    for (int c = 0; c < NCH; c++) sp[c] = '0;
    spectrum(1'b1, 1'b0);
    for (int c = 0; c < NCH; c++) sp[c] = IW'(c + 1);
    for (int s = 0; s < 4; s++) begin
      model_add(s == 0);
      spectrum(1'b0, 1'b0);
    end
    model_push();
    e = end_cyc;
    idle(24, 1'b0);
    checks++;
    if (q_dat.size() != NCH) begin errors++; $display("FAIL basic_count got %0d exp %0d", q_dat.size(), NCH); end
    for (int i = 0; i < q_dat.size() && i < exp_q.size(); i++) begin
      checks++; if (q_dat[i] != exp_q[i]) begin errors++; $display("FAIL basic_data[%0d] got %0d exp %0d", i, q_dat[i], exp_q[i]); end
      checks++; if (q_addr[i] != i) begin errors++; $display("FAIL basic_addr[%0d] got %0d exp %0d", i, q_addr[i], i); end
      checks++; if (q_last[i] != int'(i == NCH - 1)) begin errors++; $display("FAIL basic_last[%0d] got %0d", i, q_last[i]); end
      checks++; if (q_cyc[i] != e + 3 + i) begin errors++; $display("FAIL basic_timing[%0d] got cycle %0d exp %0d", i, q_cyc[i], e + 3 + i); end
      checks++; if (q_ovf[i] != 0) begin errors++; $display("FAIL basic_ovf[%0d] got %0d exp 0", i, q_ovf[i]); end
    end
  endtask

  task automatic test_free_run;
    int e0;
    do_reset(); do_sync(); clear_q();
    free_run = 1'b1;
    n_acc = NW'(1);
    fill_rand(31);
    spectrum(1'b0, 1'b0);
    e0 = 0;
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < NCH; c++) sp[c] = (k % 2 == 1) ? IW'(9) : IW'(5);
      model_add(1'b1);
      model_push();
      if (k == 5) free_run = 1'b0;
      spectrum(1'b0, 1'b0);
      if (k == 0) e0 = end_cyc;
    end
    idle(24, 1'b0);
    checks++;
    if (q_dat.size() != 6 * NCH) begin errors++; $display("FAIL free_count got %0d exp %0d", q_dat.size(), 6 * NCH); end
    for (int i = 0; i < q_dat.size() && i < exp_q.size(); i++) begin
      checks++; if (q_dat[i] != exp_q[i]) begin errors++; $display("FAIL free_data[%0d] got %0d exp %0d", i, q_dat[i], exp_q[i]); end
      checks++; if (q_addr[i] != i % NCH) begin errors++; $display("FAIL free_addr[%0d] got %0d exp %0d", i, q_addr[i], i % NCH); end
      checks++; if (q_last[i] != int'(i % NCH == NCH - 1)) begin errors++; $display("FAIL free_last[%0d] got %0d", i, q_last[i]); end
      checks++; if (q_cyc[i] != e0 + 3 + i) begin errors++; $display("FAIL free_gap[%0d] got cycle %0d exp %0d", i, q_cyc[i], e0 + 3 + i); end
    end
  endtask

  task automatic test_nacc;
    int e;
    do_reset(); do_sync(); clear_q();
    n_acc = '0;
    fill_rand(31);
    spectrum(1'b1, 1'b0);
    n_acc = NW'(3);
    fill_rand(31); model_add(1'b1); model_push();
    spectrum(1'b1, 1'b0);
    fill_rand(31); model_add(1'b1);
    spectrum(1'b0, 1'b0);
    n_acc = NW'(1);
    fill_rand(31); model_add(1'b0);
    spectrum(1'b0, 1'b0);
    fill_rand(31); model_add(1'b0); model_push();
    spectrum(1'b0, 1'b0);
    e = end_cyc;
    idle(24, 1'b0);
    checks++;
    if (q_dat.size() != 2 * NCH) begin errors++; $display("FAIL nacc_count got %0d exp %0d", q_dat.size(), 2 * NCH); end
    for (int i = 0; i < q_dat.size() && i < exp_q.size(); i++) begin
      checks++; if (q_dat[i] != exp_q[i]) begin errors++; $display("FAIL nacc_data[%0d] got %0d exp %0d", i, q_dat[i], exp_q[i]); end
      checks++; if (q_addr[i] != i % NCH) begin errors++; $display("FAIL nacc_addr[%0d] got %0d exp %0d", i, q_addr[i], i % NCH); end
    end
    if (q_cyc.size() > NCH) begin
      checks++;
      if (q_cyc[NCH] != e + 3) begin errors++; $display("FAIL nacc_timing got cycle %0d exp %0d", q_cyc[NCH], e + 3); end
    end
  endtask

  task automatic test_ce_random;
    int e1, e2;
    do_reset(); do_sync(); clear_q();
    n_acc = NW'(2);
    fill_rand(31);
    spectrum(1'b1, 1'b1);
    fill_rand(31); model_add(1'b1);
    spectrum(1'b1, 1'b1);
    fill_rand(31); model_add(1'b0); model_push();
    spectrum(1'b0, 1'b1);
    e1 = end_cyc;
    fill_rand(31); model_add(1'b1);
    spectrum(1'b0, 1'b1);
    fill_rand(31); model_add(1'b0); model_push();
    spectrum(1'b0, 1'b1);
    e2 = end_cyc;
    idle(40, 1'b1);
    checks++;
    if (q_dat.size() != 2 * NCH) begin errors++; $display("FAIL ce_count got %0d exp %0d", q_dat.size(), 2 * NCH); end
    for (int i = 0; i < q_dat.size() && i < exp_q.size(); i++) begin
      checks++; if (q_dat[i] != exp_q[i]) begin errors++; $display("FAIL ce_data[%0d] got %0d exp %0d", i, q_dat[i], exp_q[i]); end
      checks++; if (q_addr[i] != i % NCH) begin errors++; $display("FAIL ce_addr[%0d] got %0d exp %0d", i, q_addr[i], i % NCH); end
      checks++; if (q_last[i] != int'(i % NCH == NCH - 1)) begin errors++; $display("FAIL ce_last[%0d] got %0d", i, q_last[i]); end
    end
    if (q_cyc.size() > NCH) begin
      checks++; if (q_cyc[0] != e1 + 3) begin errors++; $display("FAIL ce_timing0 got cycle %0d exp %0d", q_cyc[0], e1 + 3); end
      checks++; if (q_cyc[NCH] != e2 + 3) begin errors++; $display("FAIL ce_timing1 got cycle %0d exp %0d", q_cyc[NCH], e2 + 3); end
    end
  endtask

  task automatic test_saturate;
    do_reset(); do_sync(); clear_q();
    n_acc = NW'(3);
    for (int c = 0; c < NCH; c++) sp[c] = '1;
    spectrum(1'b1, 1'b0);
    for (int s = 0; s < 3; s++) begin
      model_add(s == 0);
      spectrum(1'b0, 1'b0);
    end
    model_push();
    idle(24, 1'b0);
    checks++;
    if (q_dat.size() != NCH) begin errors++; $display("FAIL sat_count got %0d exp %0d", q_dat.size(), NCH); end
    for (int i = 0; i < q_dat.size() && i < exp_q.size(); i++) begin
      checks++; if (q_dat[i] != exp_q[i]) begin errors++; $display("FAIL sat_data[%0d] got %0d exp %0d", i, q_dat[i], exp_q[i]); end
      checks++; if (q_ovf[i] != int'(m_ovf)) begin errors++; $display("FAIL sat_ovf[%0d] got %0d exp %0d", i, q_ovf[i], m_ovf); end
    end
    checks++;
    if (ovf !== m_ovf) begin errors++; $display("FAIL sat_ovf_hold got %b exp %b", ovf, m_ovf); end
  endtask

  task automatic test_rst_mid_drain;
    bit found;
    int e;
    do_reset(); do_sync(); clear_q();
    n_acc = NW'(1);
    fill_rand(63);
    spectrum(1'b1, 1'b0);
    fill_rand(63);
    spectrum(1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (we === 1'b1 && addr === VW'(4)) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_find_addr4 got none exp we with addr 4"); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_mid_we got %b exp 0", we); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL rst_mid_data got %0d exp 0", data_out); end
    checks++; if (addr !== '0) begin errors++; $display("FAIL rst_mid_addr got %0d exp 0", addr); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL rst_mid_last got %b exp 0", last); end
    rst = 1'b0;
    clear_q();
    do_sync();
    n_acc = NW'(2);
    fill_rand(63);
    spectrum(1'b1, 1'b0);
    fill_rand(63); model_add(1'b1);
    spectrum(1'b0, 1'b0);
    fill_rand(63); model_add(1'b0); model_push();
    spectrum(1'b0, 1'b0);
    e = end_cyc;
    idle(24, 1'b0);
    checks++;
    if (q_dat.size() != NCH) begin errors++; $display("FAIL resync_count got %0d exp %0d", q_dat.size(), NCH); end
    for (int i = 0; i < q_dat.size() && i < exp_q.size(); i++) begin
      checks++; if (q_dat[i] != exp_q[i]) begin errors++; $display("FAIL resync_data[%0d] got %0d exp %0d", i, q_dat[i], exp_q[i]); end
      checks++; if (q_addr[i] != i) begin errors++; $display("FAIL resync_addr[%0d] got %0d exp %0d", i, q_addr[i], i); end
    end
    if (q_cyc.size() > 0) begin
      checks++;
      if (q_cyc[0] != e + 3) begin errors++; $display("FAIL resync_timing got cycle %0d exp %0d", q_cyc[0], e + 3); end
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; sync = 1'b0; trig = 1'b0; free_run = 1'b0;
    data_in = '0; n_acc = NW'(1);
    test_reset();
    test_basic();
    test_free_run();
    test_nacc();
    test_ce_random();
    test_saturate();
    test_rst_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vacc_pp.md
# vacc_pp

Ping-pong vector accumulator, next generation of the spectrometer's vector accumulator. It integrates a stream of per-channel power values (one channel per enabled cycle, 2^VECTOR_WIDTH channels per spectrum) over a runtime-programmable number of spectra. It accumulates into one RAM bank while the previous integration drains from the other, so there is no dead time between integrations. It sits between the power-detect stage and the output/packetiser RAM, and supports one-shot (per-trigger) and free-running modes.

## Interface
Parameters:
- VECTOR_WIDTH, 11, log2 of channels per spectrum
- INPUT_WIDTH, 36, unsigned input sample width
- OUTPUT_WIDTH, 64, accumulator/output width (> INPUT_WIDTH)
- NACC_WIDTH, 16, width of runtime accumulation-count port

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ce  in  1  clock enable; all state frozen when low
- data_in  in  INPUT_WIDTH  unsigned sample for current channel
- sync  in  1  spectrum alignment pulse
- trig  in  1  start-integration request
- free_run  in  1  1 = back-to-back integrations, 0 = one per trig
- n_acc  in  NACC_WIDTH  spectra per integration; 0 treated as 1
- data_out  out  OUTPUT_WIDTH  drained sum, zero when we=0
- we  out  1  drained word valid
- addr  out  VECTOR_WIDTH  channel index of data_out, zero when we=0
- last  out  1  high with final drained word (addr = all ones)
- ovf  out  1  sticky overflow flag for current drain

## Operation
- "Cycle" means clk edge with ce=1. Clock and reset are as decided: one clock `clk`; reset `rst` synchronous, active-high.
- Channel counter `chan`: held at 0 until sync is seen. The cycle after sync presents channel 0, then it increments each cycle and wraps at 2^VECTOR_WIDTH-1. Later sync pulses are ignored until rst.
- FSM states:
  - WAIT_SYNC: goes to WAIT_TRIG on sync.
  - WAIT_TRIG: goes to ARMED on trig, or immediately if free_run=1.
  - ARMED: goes to RUN when chan = all ones. At that point it latches n_acc (0 becomes 1), clears the spectrum counter, and selects the accumulate bank.
  - RUN: after the spectrum counter reaches the latched count at chan = all ones:
    - swaps banks and launches a drain of the finished bank;
    - then goes to ARMED (free_run=1 or trig pending) or WAIT_TRIG.
- trig during ARMED/RUN sets a pending flag consumed at the next integration end, giving at most one queued integration. Integrations are always back-to-back spectra.
- Accumulation:
  - bank[chan] += data_in, zero-extended.
  - On the first spectrum of an integration, the RAM read value is replaced by 0. No clear sweep is ever needed, and stale bank contents after reset are harmless.
- Drain:
  - Reads the finished bank sequentially, channels 0 to 2^VECTOR_WIDTH-1, one word per cycle.
  - Uses a separate read port from accumulation, with one 2-port RAM per bank.
  - A drain always finishes before the next one starts, including n_acc=1.
- rst: state to WAIT_SYNC, chan to 0, pending/ovf cleared, any drain aborted. Outputs are zero the following cycle.

## Timing
- Reset values: data_out=0, we=0, addr=0, last=0, ovf=0.
- Accumulate pipeline is read, add, write (3 cycles). The RAM models read-before-write, and there is no same-address hazard because stride = 2^VECTOR_WIDTH ≥ 4.
- Drain latency: first we=1 (addr=0) is exactly 3 cycles after the cycle that presented the final channel (all ones) of the last spectrum.
- Drain timing: we stays high for 2^VECTOR_WIDTH consecutive cycles. addr increments by 1 each cycle, and last is high only on the final word.
- ce low mid-drain stalls the drain and holds outputs.
- ovf: cleared at each drain start. It becomes valid with the first drained word and holds until the next drain start.
- Back-to-back (n_acc=1): drains are contiguous with a 0-cycle gap.

## Configuration
- VACC_SATURATE_EN defined:
  - Each add clamps to 2^OUTPUT_WIDTH-1.
  - Any clamp during the integration sets ovf for that integration's drain.
- VACC_SATURATE_EN not defined:
  - Adds wrap modulo 2^OUTPUT_WIDTH.
  - ovf is tied to 0.

## Test plan
- VECTOR_WIDTH=3, sync, trig, n_acc=4, data_in=chan+1 -> one drain 3 cycles after the 4th spectrum's channel 7; addr 0..7; data_out=4,8,…,32; last on addr 7.
- free_run=1, n_acc=1, data_in alternates spectrum values 5 / 9 -> continuous drains with no gap: all words 5, then all 9, alternating; no we gaps.
- n_acc=0 -> behaves as n_acc=1; n_acc changed mid-RUN -> current integration keeps the old count.
- ce toggled pseudo-randomly at 50% during RUN and drain -> results identical to the ce=1 run.
- OUTPUT_WIDTH=INPUT_WIDTH+1, data_in all ones, n_acc=3 -> with VACC_SATURATE_EN: data_out=2^OUTPUT_WIDTH-1, ovf=1; without: wrapped sum, ovf=0.
- rst asserted mid-drain at addr 4 -> we=0 next cycle. Re-sync, trig, n_acc=2 -> correct sums with no stale-bank contribution.
